// File: rtl/bus_arbiter.sv
// bus_arbiter: four-master round-robin arbiter for the Yutorina system bus.
//
// Requests and grants are active-low. Exactly one grant is asserted while the
// bus is owned; ownership is held until the owner releases its request (no
// preemption). On release, the grant moves directly to the next requester in
// round-robin order (owner+1, owner+2, owner+3, owner), so a releasing master
// is lowest priority. All outputs are registered; nothing is combinational
// from request to grant.
//
// Optional feature macro: YUTORINA_BUS_ARBITER_WATCHDOG_EN
//   When defined, an ownership watchdog revokes a grant held for TIMEOUT
//   consecutive cycles and pulses `timeout` for one cycle. When undefined,
//   no counter is built and `timeout` is tied low.
//
// Parameters:
//   TIMEOUT      watchdog limit in cycles of continuous ownership (1..65535)
//
// Ports:
//   clk                      system clock, rising edge
//   reset                    asynchronous, active-high reset
//   m0_request_..m3_request_ active-low bus requests from masters 0..3
//   m0_grant_..m3_grant_     active-low registered grants, at most one low
//   owner                    index of current/last granted master (mux select)
//   bus_busy                 high while a grant is asserted
//   timeout                  one-cycle pulse when the watchdog revokes a grant

module bus_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       m0_request_,
  input  logic       m1_request_,
  input  logic       m2_request_,
  input  logic       m3_request_,
  output logic       m0_grant_,
  output logic       m1_grant_,
  output logic       m2_grant_,
  output logic       m3_grant_,
  output logic [1:0] owner,
  output logic       bus_busy,
  output logic       timeout
);

  typedef enum logic {
    StIdle,
    StGrant
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] owner_q, owner_d;
  logic [3:0] grant_n_q, grant_n_d;
  logic       busy_q, busy_d;

  logic [3:0] req;       // active-high view of the request lines
  logic [3:0] owner_oh;
  logic [2:0] pick;      // {found, index}
  logic       wd_fire;

  assign req      = ~{m3_request_, m2_request_, m1_request_, m0_request_};
  assign owner_oh = 4'b0001 << owner_q;

  // First asserted request searching from last+1 round to last itself.
  // Iterating offsets downward lets the smallest offset overwrite the result.
  function automatic logic [2:0] rr_pick(input logic [1:0] last, input logic [3:0] reqs);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (reqs[idx]) begin
        res = {1'b1, idx};
      end
    end
    return res;
  endfunction

`ifdef YUTORINA_BUS_ARBITER_WATCHDOG_EN
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  // Fires on the edge that ends the TIMEOUT-th owned cycle.
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            timeout_q, timeout_d;

  assign wd_fire = (state_q == StGrant) && req[owner_q] && (cnt_q == CntLast);
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign wd_fire        = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    pick    = 3'b000;

    case (state_q)
      StIdle: begin
        pick = rr_pick(owner_q, req);
        if (pick[2]) begin
          owner_d = pick[1:0];
          state_d = StGrant;
        end
      end
      StGrant: begin
        if (!req[owner_q] || wd_fire) begin
          // Owner is excluded: released, or masked for this edge after a revoke.
          pick = rr_pick(owner_q, req & ~owner_oh);
          if (pick[2]) begin
            owner_d = pick[1:0];
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    grant_n_d = 4'hF;
    if (state_d == StGrant) begin
      grant_n_d[owner_d] = 1'b0;
    end
    busy_d = (state_d == StGrant);
  end

`ifdef YUTORINA_BUS_ARBITER_WATCHDOG_EN
  always_comb begin
    timeout_d = wd_fire;
    // Any path other than a plain hold is a new grant (or idle): restart count.
    if ((state_q == StGrant) && req[owner_q] && !wd_fire) begin
      cnt_d = cnt_q + CntW'(1);
    end else begin
      cnt_d = '0;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      owner_q   <= 2'd3;
      grant_n_q <= 4'hF;
      busy_q    <= 1'b0;
`ifdef YUTORINA_BUS_ARBITER_WATCHDOG_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      grant_n_q <= grant_n_d;
      busy_q    <= busy_d;
`ifdef YUTORINA_BUS_ARBITER_WATCHDOG_EN
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign m0_grant_ = grant_n_q[0];
  assign m1_grant_ = grant_n_q[1];
  assign m2_grant_ = grant_n_q[2];
  assign m3_grant_ = grant_n_q[3];
  assign owner     = owner_q;
  assign bus_busy  = busy_q;
`ifdef YUTORINA_BUS_ARBITER_WATCHDOG_EN
  assign timeout   = timeout_q;
`else
  assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Testbench for bus_arbiter: directed vector table, hand-written corner
// sequences (async reset mid-ownership, long hold with/without watchdog),
// and randomized requests checked against a behavioural reference model.

module tb_bus_arbiter;

  localparam int TbTimeout = 4;

  logic       clk;
  logic       reset;
  logic       m0_request_, m1_request_, m2_request_, m3_request_;
  logic       m0_grant_, m1_grant_, m2_grant_, m3_grant_;
  logic [1:0] owner;
  logic       bus_busy;
  logic       timeout;

  bus_arbiter #(
    .TIMEOUT(TbTimeout)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .m0_request_(m0_request_),
    .m1_request_(m1_request_),
    .m2_request_(m2_request_),
    .m3_request_(m3_request_),
    .m0_grant_  (m0_grant_),
    .m1_grant_  (m1_grant_),
    .m2_grant_  (m2_grant_),
    .m3_grant_  (m3_grant_),
    .owner      (owner),
    .bus_busy   (bus_busy),
    .timeout    (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: who owns the bus, whether it is owned, and how long.
  int m_owner;
  bit m_busy;
  int m_cnt;
  bit m_to;

`ifdef YUTORINA_BUS_ARBITER_WATCHDOG_EN
  localparam bit WdOn = 1'b1;
`else
  localparam bit WdOn = 1'b0;
`endif

  function automatic logic [3:0] grants();
    return {m3_grant_, m2_grant_, m1_grant_, m0_grant_};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = 3;
    m_busy  = 1'b0;
    m_cnt   = 0;
    m_to    = 1'b0;
  endtask

  // One rising edge of the rules, with req active-high.
  task automatic model_edge(input logic [3:0] req);
    int win;
    m_to = 1'b0;
    if (m_busy && req[m_owner]) begin
      if (!(WdOn && (m_cnt + 1 == TbTimeout))) begin
        m_cnt++;
        return;
      end
      m_to = 1'b1;
    end
    win = -1;
    for (int off = 4; off >= 1; off--) begin
      int idx;
      idx = (m_owner + off) % 4;
      if (req[idx] && !(m_busy && idx == m_owner)) win = idx;
    end
    m_cnt = 0;
    if (win >= 0) begin
      m_owner = win;
      m_busy  = 1'b1;
    end else begin
      m_busy  = 1'b0;
    end
  endtask

  task automatic model_check(input string tag);
    logic [3:0] eg;
    eg = 4'hF;
    if (m_busy) eg[m_owner] = 1'b0;
    check({tag, ".grant_"}, 32'(grants()), 32'(eg));
    check({tag, ".owner"}, 32'(owner), 32'(m_owner));
    check({tag, ".bus_busy"}, 32'(bus_busy), 32'(m_busy));
    check({tag, ".timeout"}, 32'(timeout), 32'(m_to));
  endtask

  task automatic drive(input logic [3:0] req_n);
    {m3_request_, m2_request_, m1_request_, m0_request_} = req_n;
  endtask

  // Drive requests, take one edge, sample 1 ns later.
  task automatic step(input logic [3:0] req_n);
    drive(req_n);
    @(posedge clk);
    model_edge(~req_n);
    #1;
  endtask

  // Async reset pulse well away from any rising edge; outputs stay at reset
  // values until the next edge.
  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    #1;
    reset = 1'b0;
  endtask

  typedef struct {
    bit         rst;
    logic [3:0] req_n;
    logic [3:0] exp_grant_n;
    logic [1:0] exp_owner;
    logic       exp_busy;
  } vec_t;

  vec_t tbl[14];

  initial begin
    reset = 1'b1;
    drive(4'hF);
    model_reset();

    // {rst, req_n {m3..m0}, grant_n {m3..m0}, owner, busy}
    tbl[0]  = '{1'b1, 4'hF,    4'hF,    2'd3, 1'b0}; // reset state
    tbl[1]  = '{1'b0, 4'b1011, 4'b1011, 2'd2, 1'b1}; // m2 alone
    tbl[2]  = '{1'b0, 4'hF,    4'hF,    2'd2, 1'b0}; // release -> idle
    tbl[3]  = '{1'b1, 4'hF,    4'hF,    2'd3, 1'b0};
    tbl[4]  = '{1'b0, 4'b0000, 4'b1110, 2'd0, 1'b1}; // all request: m0 first
    tbl[5]  = '{1'b0, 4'b0001, 4'b1101, 2'd1, 1'b1}; // handover, no gap
    tbl[6]  = '{1'b0, 4'b0011, 4'b1011, 2'd2, 1'b1};
    tbl[7]  = '{1'b0, 4'b0111, 4'b0111, 2'd3, 1'b1};
    tbl[8]  = '{1'b0, 4'hF,    4'hF,    2'd3, 1'b0};
    tbl[9]  = '{1'b0, 4'b1101, 4'b1101, 2'd1, 1'b1}; // m1 owns
    tbl[10] = '{1'b0, 4'b0100, 4'b1101, 2'd1, 1'b1}; // m0,m3 wait, no preempt
    tbl[11] = '{1'b0, 4'b0110, 4'b0111, 2'd3, 1'b1}; // m1 releases: m3 next
    tbl[12] = '{1'b0, 4'b1110, 4'b1110, 2'd0, 1'b1}; // m3 releases: m0
    tbl[13] = '{1'b0, 4'hF,    4'hF,    2'd0, 1'b0};

    #2;
    for (int i = 0; i < 14; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      if (tbl[i].rst) pulse_reset();
      else step(tbl[i].req_n);
      check({tag, ".grant_"}, 32'(grants()), 32'(tbl[i].exp_grant_n));
      check({tag, ".owner"}, 32'(owner), 32'(tbl[i].exp_owner));
      check({tag, ".bus_busy"}, 32'(bus_busy), 32'(tbl[i].exp_busy));
      check({tag, ".timeout"}, 32'(timeout), 32'd0);
    end

    // Async reset while m0 owns: grant drops with no clock edge.
    pulse_reset();
    step(4'b1110);
    step(4'b1110);
    check("pre_rst.m0_grant_", 32'(m0_grant_), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    #1;
    check("async_rst.m0_grant_", 32'(m0_grant_), 32'd1);
    check("async_rst.owner", 32'(owner), 32'd3);
    check("async_rst.bus_busy", 32'(bus_busy), 32'd0);
    reset = 1'b0;
    step(4'b1110);
    check("post_rst.m0_grant_", 32'(m0_grant_), 32'd0);
    check("post_rst.owner", 32'(owner), 32'd0);
    step(4'hF);

    // m1 holds with m2 waiting.
    pulse_reset();
    step(4'b1101);
    check("hold.m1_start", 32'(m1_grant_), 32'd0);
`ifdef YUTORINA_BUS_ARBITER_WATCHDOG_EN
    for (int k = 1; k <= TbTimeout; k++) begin
      step(4'b1001);
      if (k < TbTimeout) begin
        check("wd.m1_held", 32'(m1_grant_), 32'd0);
        check("wd.no_pulse", 32'(timeout), 32'd0);
      end
    end
    check("wd.timeout_pulse", 32'(timeout), 32'd1);
    check("wd.m1_revoked", 32'(m1_grant_), 32'd1);
    check("wd.m2_granted", 32'(m2_grant_), 32'd0);
    step(4'b1001);
    check("wd.pulse_one_cycle", 32'(timeout), 32'd0);
`else
    for (int k = 0; k < 1000; k++) begin
      step(4'b1001);
      check("nowd.m1_held", 32'(m1_grant_), 32'd0);
      check("nowd.timeout", 32'(timeout), 32'd0);
    end
    check("nowd.m2_waiting", 32'(m2_grant_), 32'd1);
`endif
    step(4'hF);

    // Randomized requests against the model; each line asserted ~3/4 of cycles.
    pulse_reset();
    for (int c = 0; c < 400; c++) begin
      logic [3:0] rn;
      for (int b = 0; b < 4; b++) rn[b] = ($urandom_range(3) == 0);
      step(rn);
      model_check("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Round-robin arbiter that shares the Yutorina system bus between four bus masters. It takes active-low request lines from the masters and issues exactly one active-low grant. It also drives a 2-bit owner index, which steers the master-side address/data/control multiplexer. The slave-side return path (read data, ready) is selected independently by chip select and is outside this block.

## Interface
Parameters:
- TIMEOUT, 255: watchdog limit in cycles of continuous ownership; legal range 1..65535; used only with YUTORINA_BUS_ARBITER_WATCHDOG_EN.

Ports (one clock; reset is asynchronous and active-high):
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- m0_request_ .. m3_request_  input  1 each  bus request from master n, active-low (`YUTORINA_ENABLE_ = asserted).
- m0_grant_ .. m3_grant_  output  1 each  bus grant to master n, active-low, registered; at most one asserted.
- owner  output  2  index of the current/last granted master, registered; drives the master-side mux select.
- bus_busy  output  1  high while a grant is asserted (state GRANT).
- timeout  output  1  one-cycle pulse when the watchdog revokes a grant; constant 0 when the watchdog is compiled out.

## Operation
- States: IDLE (no grant), GRANT (one grant asserted to master `owner`).
- Round-robin search order: owner+1, owner+2, owner+3, owner (mod 4). The first asserted request in that order wins. owner is lowest priority, so a releasing master cannot immediately regain the bus while others wait.
- IDLE: if any request_ is asserted, latch the winner into owner, assert its grant_, and go to GRANT. With no request, stay in IDLE; owner is unchanged and all grant_ are high.
- GRANT, owner's request_ still asserted: hold the grant. Requests from other masters are ignored (no preemption).
- GRANT, owner's request_ deasserted: run the search over the remaining requests.
  - Winner found: move the grant directly to the winner (no idle bubble); stay in GRANT.
  - No winner: deassert all grant_; go to IDLE.
- Grant changes only on a clock edge. A requester must keep request_ asserted until it sees its grant_.
- owner always equals the index of the asserted grant_ while bus_busy = 1.
- Reset (async, at any time, including mid-transfer):
  - all grant_ = 1 (`YUTORINA_DISABLE_), bus_busy = 0, timeout = 0;
  - owner = 2'd3, so master 0 wins first after reset;
  - state = IDLE; watchdog counter = 0.

## Timing
- Request to grant: a request sampled asserted at edge t in IDLE gives grant_ low after edge t (visible in cycle t+1). Latency is 1 cycle.
- Release to handover: owner's request_ deasserted at edge t gives the old grant_ high and the new grant_ low, both after edge t. There is no cycle with two grants, and no dead cycle when another master is waiting.
- Release to idle: grant_ high and bus_busy low after the edge that samples the release.
- Simultaneous requests from several masters in IDLE: one winner per round-robin order; the others wait, and each is granted in turn on successive releases.
- Outputs are pure flops; there is no combinational path from request_ to grant_.

## Configuration
- Macro: YUTORINA_BUS_ARBITER_WATCHDOG_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT+1) clears on every new grant and increments each GRANT cycle while owner's request_ stays asserted.
  - On the edge where the count equals TIMEOUT, the grant is revoked: timeout pulses high for 1 cycle.
  - The search then runs with owner's request masked for that edge only. If another master wins, the grant moves to it. If none, the block goes to IDLE, and the timed-out master is re-granted by the normal IDLE rule on the next edge if it still requests.
- Undefined:
  - No counter is built; timeout is tied to 0.
  - A grant is held for as long as the owner requests it.

## Test plan
- Reset, then m2_request_ = 0 alone: m2_grant_ = 0 one cycle later, owner = 2, bus_busy = 1; all other grants stay high.
- After reset, all four requests asserted together: grants go to 0, 1, 2, 3 in order, each handed over in the cycle after the previous owner releases, with no gap and never two grants at once.
- m1 owns the bus, m0 and m3 request, then m1 releases: m3 is granted (search order 2, 3, 0, 1), then m0 is granted after m3 releases.
- m0 owns the bus, async reset pulsed mid-cycle: m0_grant_ goes high immediately without waiting for a clock edge, owner = 3, bus_busy = 0; the next request from m0 is granted 1 cycle later.
- Watchdog enabled with TIMEOUT = 4, m1 holds its request and m2 requests: timeout pulses after 4 owned cycles, and m2_grant_ = 0 in the same cycle that m1_grant_ = 1.
- Watchdog compiled out, m1 holds its request for 1000 cycles with m2 requesting: m1 keeps the grant throughout, and timeout stays 0.
